pwm_compare_unit: RTL and testbench
===================================

Name: pwm_compare_unit

Overview:
- Consumer side of the modulo-2500 up/down timer count bus: reads the 32-bit count value and its direction.
- Produces a complementary PWM pair (pwm_h/pwm_l) with dead-time insertion.
- Duty value is written by the control side over a valid/ready handshake, buffered in a shadow register and applied only at period boundaries.
- Sits between the timer counter and the power-stage gate drivers.

Parameters:
PERIOD, 2500, counter modulus; count values range over 0..PERIOD-1
DEAD_TIME, 8, clk cycles during which both outputs are low at every switching edge; legal range 1..255
WIDTH, 32, width of count and duty buses

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
clr  input  1  synchronous clear, active-low; same effect as reset, applied on the clk edge
cnt_in  input  WIDTH  count value from timer counter, 0..PERIOD-1
cnt_dir  input  1  counter direction (1 = counting down); used only for boundary detection
duty_in  input  WIDTH  requested duty, in counts
duty_valid  input  1  duty_in is valid
duty_ready  output  1  shadow register free; a transfer occurs when valid and ready are both high on a clk edge
duty_active  output  WIDTH  duty currently applied
pwm_h  output  1  high-side gate
pwm_l  output  1  low-side gate
period_start  output  1  one-cycle pulse at each period boundary

Behaviour:
- Reset/clr values:
  - duty_active = 0, shadow empty, duty_ready = 1.
  - pwm_h = 0, pwm_l = 1, period_start = 0.
  - FSM in L_ON, dead counter = 0, prev_cnt register = 0.
- Boundary:
  - Up count (cnt_dir = 0): cnt_in == 0 && prev_cnt == PERIOD-1.
  - Down count (cnt_dir = 1): cnt_in == PERIOD-1 && prev_cnt == 0.
  - prev_cnt samples cnt_in every cycle.
  - period_start is registered and pulses high for 1 cycle, the cycle after the boundary is seen.
- Handshake:
  - duty_ready = !shadow_full.
  - On a transfer, duty_in is clamped to PERIOD (values > PERIOD become PERIOD) and stored in the shadow; shadow_full is set.
  - At a boundary with shadow_full = 1: duty_active <= shadow, shadow_full <= 0.
  - Transfer in the same cycle as a boundary: the clamped duty_in goes straight to duty_active and shadow_full stays 0.
  - duty_valid with duty_ready = 0 is held off; the value is neither lost nor overwritten.
- Compare:
  - raw = (cnt_in < duty_active), evaluated with the duty_active value as of the current cycle.
  - duty_active = 0 gives raw always 0; duty_active = PERIOD gives raw always 1.
- Dead-time FSM (registered outputs):
  - L_ON: pwm_l = 1, pwm_h = 0. raw = 1 -> DT_H, load dead counter with DEAD_TIME-1.
  - DT_H: both outputs 0. raw = 0 -> L_ON (abort; pwm_l back high next cycle). Otherwise, counter == 0 -> H_ON; else decrement.
  - H_ON: pwm_h = 1, pwm_l = 0. raw = 0 -> DT_L, load counter with DEAD_TIME-1.
  - DT_L: both outputs 0. raw = 1 -> H_ON (abort). Otherwise, counter == 0 -> L_ON; else decrement.
- Latency:
  - pwm outputs go low 1 cycle after the cycle raw changes.
  - The opposite output goes high DEAD_TIME+1 cycles after the raw change.
- Invariant: pwm_h && pwm_l is never 1, under any stimulus, including reset or clr asserted mid-dead-time.
- Asynchronous reset mid-operation forces the reset values immediately; clr forces them on the next edge.
- cnt_in values ≥ PERIOD are not legal. They still compare arithmetically and do not generate a boundary.

Test Plan:
- Reset, cnt_in ramps up 0..2499 repeatedly, no duty written -> pwm_l = 1 and pwm_h = 0 throughout; period_start pulses once per 2500 cycles, 1 cycle after cnt_in = 0.
- Write duty = 1000 mid-period at count 500 -> duty_ready drops to 0 for the next cycle; duty_active becomes 1000 only at the next wrap; ready returns to 1.
- Then in the following period:
  - pwm_l falls 1 cycle after count 0; pwm_h rises 9 cycles after count 0.
  - pwm_h falls 1 cycle after count 1000; pwm_l rises 9 cycles after count 1000.
- Write duty = 3000 -> duty_active = 2500, pwm_h stays high all period. Then write duty = 0 -> pwm_h low all period after the next boundary.
- Duty = 1003, cnt_in driven around 1000 so raw toggles for 3 cycles -> FSM aborts DT_H back to L_ON; pwm_h never asserts; pwm_h & pwm_l == 0 checked every cycle.
- Down-count mode (cnt_dir = 1, 2499..0), transfer at the boundary cycle -> immediate load with duty_ready staying 1; second write while shadow is full is stalled until the next boundary; assert rst mid DT_H -> pwm_l = 1 and pwm_h = 0 asynchronously.

Source files
------------

// File: rtl/pwm_compare_unit.sv
// pwm_compare_unit
//   Consumer of the modulo-PERIOD up/down timer count bus. Compares the
//   count against the applied duty and drives a complementary gate pair
//   with dead-time insertion at every switching edge. New duty values
//   arrive over a valid/ready handshake, wait in a one-entry shadow
//   register and are applied only at period boundaries.
//
// Ports
//   clk           clock
//   rst           asynchronous reset, active-low
//   clr           synchronous clear, active-low (same effect as rst)
//   cnt_in        timer count, 0..PERIOD-1
//   cnt_dir       timer direction, 1 = counting down (boundary detection only)
//   duty_in       requested duty in counts
//   duty_valid    duty_in valid
//   duty_ready    shadow register free
//   duty_active   duty currently applied
//   pwm_h/pwm_l   high-side / low-side gate drives
//   period_start  one-cycle pulse, one cycle after a period boundary
module pwm_compare_unit #(
    parameter int unsigned PERIOD    = 2500,
    parameter int unsigned DEAD_TIME = 8,
    parameter int unsigned WIDTH     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cnt_dir,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic [WIDTH-1:0] duty_active,
    output logic             pwm_h,
    output logic             pwm_l,
    output logic             period_start
);

    localparam logic [WIDTH-1:0] PERIOD_W = WIDTH'(PERIOD);
    localparam logic [WIDTH-1:0] LAST_W   = WIDTH'(PERIOD - 1);
    localparam logic [7:0]       DT_LOAD  = 8'(DEAD_TIME - 1);

    typedef enum logic [1:0] {
        L_ON,
        DT_H,
        H_ON,
        DT_L
    } state_e;

    logic [WIDTH-1:0] prev_cnt_q;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             shadow_full_q, shadow_full_d;
    logic [WIDTH-1:0] duty_active_q, duty_active_d;
    logic             period_start_q;
    state_e           state_q;
    logic [7:0]       dead_q;
    logic             pwm_h_q, pwm_l_q;

    logic             boundary;
    logic             transfer;
    logic             raw;
    logic [WIDTH-1:0] duty_clamped;

    // Wrap detection in either direction; illegal counts never match.
    assign boundary = cnt_dir ? (cnt_in == LAST_W && prev_cnt_q == '0)
                              : (cnt_in == '0 && prev_cnt_q == LAST_W);

    assign transfer     = duty_valid && !shadow_full_q;
    assign duty_clamped = (duty_in > PERIOD_W) ? PERIOD_W : duty_in;
    assign raw          = cnt_in < duty_active_q;

    always_comb begin
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        duty_active_d = duty_active_q;
        if (boundary && transfer) begin
            // Shadow is necessarily empty here, so bypass it.
            duty_active_d = duty_clamped;
        end else begin
            if (boundary && shadow_full_q) begin
                duty_active_d = shadow_q;
                shadow_full_d = 1'b0;
            end
            if (transfer) begin
                shadow_d      = duty_clamped;
                shadow_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_cnt_q     <= '0;
            shadow_q       <= '0;
            shadow_full_q  <= 1'b0;
            duty_active_q  <= '0;
            period_start_q <= 1'b0;
        end else if (!clr) begin
            prev_cnt_q     <= '0;
            shadow_q       <= '0;
            shadow_full_q  <= 1'b0;
            duty_active_q  <= '0;
            period_start_q <= 1'b0;
        end else begin
            prev_cnt_q     <= cnt_in;
            shadow_q       <= shadow_d;
            shadow_full_q  <= shadow_full_d;
            duty_active_q  <= duty_active_d;
            period_start_q <= boundary;
        end
    end

    // Dead-time FSM. Outputs are registered alongside the state, and the
    // only paths into H_ON/L_ON pass through a both-low state, so the two
    // gates can never be high together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= L_ON;
            dead_q  <= '0;
            pwm_h_q <= 1'b0;
            pwm_l_q <= 1'b1;
        end else if (!clr) begin
            state_q <= L_ON;
            dead_q  <= '0;
            pwm_h_q <= 1'b0;
            pwm_l_q <= 1'b1;
        end else begin
            case (state_q)
                L_ON: begin
                    if (raw) begin
                        state_q <= DT_H;
                        dead_q  <= DT_LOAD;
                        pwm_l_q <= 1'b0;
                    end
                end
                DT_H: begin
                    if (!raw) begin
                        state_q <= L_ON;
                        pwm_l_q <= 1'b1;
                    end else if (dead_q == '0) begin
                        state_q <= H_ON;
                        pwm_h_q <= 1'b1;
                    end else begin
                        dead_q <= dead_q - 8'd1;
                    end
                end
                H_ON: begin
                    if (!raw) begin
                        state_q <= DT_L;
                        dead_q  <= DT_LOAD;
                        pwm_h_q <= 1'b0;
                    end
                end
                DT_L: begin
                    if (raw) begin
                        state_q <= H_ON;
                        pwm_h_q <= 1'b1;
                    end else if (dead_q == '0) begin
                        state_q <= L_ON;
                        pwm_l_q <= 1'b1;
                    end else begin
                        dead_q <= dead_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= L_ON;
                    pwm_h_q <= 1'b0;
                    pwm_l_q <= 1'b1;
                end
            endcase
        end
    end

    assign duty_ready   = !shadow_full_q;
    assign duty_active  = duty_active_q;
    assign pwm_h        = pwm_h_q;
    assign pwm_l        = pwm_l_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_compare_unit.sv
// Testbench for pwm_compare_unit: behavioural model plus directed scenarios.
module tb_pwm_compare_unit;

    localparam int P  = 2500;
    localparam int DT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] cnt_in = '0;
    logic        cnt_dir = 1'b0;
    logic [31:0] duty_in = '0;
    logic        duty_valid = 1'b0;
    logic        duty_ready;
    logic [31:0] duty_active;
    logic        pwm_h, pwm_l, period_start;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: applied duty, one-entry shadow, boundary history, and the
    // gate pair described as "side last driven" plus how many consecutive
    // cycles the request has disagreed with that side.
    int m_prev = 0, m_active = 0, m_shadow = 0, m_full = 0, m_ps = 0;
    int m_side = 0, m_run = 0, m_h = 0, m_l = 1;

    always #5 clk = ~clk;

    pwm_compare_unit #(.PERIOD(P), .DEAD_TIME(DT), .WIDTH(32)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .cnt_in(cnt_in), .cnt_dir(cnt_dir),
        .duty_in(duty_in), .duty_valid(duty_valid), .duty_ready(duty_ready),
        .duty_active(duty_active),
        .pwm_h(pwm_h), .pwm_l(pwm_l), .period_start(period_start)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_active = 0; m_shadow = 0; m_full = 0; m_ps = 0;
        m_side = 0; m_run = 0; m_h = 0; m_l = 1;
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("pwm_h", pwm_h, m_h);
        check("pwm_l", pwm_l, m_l);
        check("period_start", period_start, m_ps);
        check("duty_active", duty_active, m_active);
        check("duty_ready", duty_ready, (m_full == 0) ? 1 : 0);
        check("no_overlap", pwm_h & pwm_l, 0);
    end

    // One clock: evaluate the model on the pre-edge inputs, commit after it.
    task automatic tick();
        int a = m_active, s = m_shadow, f = m_full;
        int side = m_side, run = m_run, h = m_h, l = m_l;
        int ps = 0, pv = 0, cl, want, c;
        bit bnd = 0, xfer = 0;
        c = int'(cnt_in);
        if (!rst || !clr) begin
            a = 0; s = 0; f = 0; side = 0; run = 0; h = 0; l = 1;
        end else begin
            bnd  = cnt_dir ? (c == P - 1 && m_prev == 0) : (c == 0 && m_prev == P - 1);
            xfer = duty_valid && (m_full == 0);
            cl   = (duty_in > 32'(P)) ? P : int'(duty_in);
            want = (c < m_active) ? 1 : 0;
            if (want == side) begin
                run = 0; h = side; l = 1 - side;
            end else begin
                run++;
                if (run >= DT + 1) begin
                    side = want; run = 0; h = side; l = 1 - side;
                end else begin
                    h = 0; l = 0;
                end
            end
            if (bnd && xfer) a = cl;
            else begin
                if (bnd && f == 1) begin a = s; f = 0; end
                if (xfer) begin s = cl; f = 1; end
            end
            ps = bnd ? 1 : 0;
            pv = c;
        end
        @(posedge clk);
        #1;
        m_active = a; m_shadow = s; m_full = f; m_side = side; m_run = run;
        m_h = h; m_l = l; m_ps = ps; m_prev = pv;
        if (xfer) duty_valid = 1'b0;
    endtask

    task automatic cyc();
        tick();
        if (cnt_dir) cnt_in = (cnt_in == 0) ? 32'(P - 1) : cnt_in - 1;
        else         cnt_in = (cnt_in == 32'(P - 1)) ? 32'd0 : cnt_in + 1;
    endtask

    task automatic run_to(input int target);
        int k = 0;
        while (int'(cnt_in) != target && k < 3000) begin cyc(); k++; end
        if (int'(cnt_in) != target) begin
            n_tests++; n_fail++;
            $display("FAIL run_to: cnt %0d required %0d", cnt_in, target);
        end
    endtask

    task automatic hold(input int v, input int n);
        cnt_in = 32'(v);
        repeat (n) tick();
    endtask

    task automatic write(input int v);
        duty_in = 32'(v);
        duty_valid = 1'b1;
    endtask

    initial begin
        int pulses, hs, cnt, lf, hr, hf, lr, lows;
        logic ph, pl;

        // Reset state
        repeat (3) tick();
        check("rst_pwm_l", pwm_l, 1);
        check("rst_pwm_h", pwm_h, 0);
        check("rst_ready", duty_ready, 1);
        check("rst_active", duty_active, 0);
        rst = 1'b1;

        // Free-running up count, no duty written
        pulses = 0; hs = 0;
        repeat (5001) begin
            cyc();
            if (period_start) begin
                pulses++;
                check("ps_after_cnt0", cnt_in, 1);
            end
            if (pwm_h) hs++;
        end
        check("ps_pulses", pulses, 2);
        check("idle_pwm_h_cycles", hs, 0);

        // Duty 1000 written mid-period, applied at the wrap
        run_to(500);
        write(1000);
        cyc();
        check("ready_after_write", duty_ready, 0);
        run_to(0);
        check("active_before_wrap", duty_active, 0);
        cyc();
        check("active_after_wrap", duty_active, 1000);
        check("ready_after_wrap", duty_ready, 1);
        run_to(0);
        lf = -1; hr = -1; hf = -1; lr = -1;
        repeat (P) begin
            ph = pwm_h; pl = pwm_l;
            cyc();
            if (pl && !pwm_l && lf < 0) lf = int'(cnt_in);
            if (!ph && pwm_h && hr < 0) hr = int'(cnt_in);
            if (ph && !pwm_h && hf < 0) hf = int'(cnt_in);
            if (!pl && pwm_l && lr < 0) lr = int'(cnt_in);
        end
        check("pwm_l_fall_cnt", lf, 1);
        check("pwm_h_rise_cnt", hr, 9);
        check("pwm_h_fall_cnt", hf, 1001);
        check("pwm_l_rise_cnt", lr, 1009);

        // Clamp to PERIOD, then duty 0
        write(3000);
        cyc();
        run_to(0);
        cyc();
        check("clamped_active", duty_active, 2500);
        run_to(0);
        cnt = 0;
        repeat (P) begin cyc(); if (!pwm_h) cnt++; end
        check("full_duty_h_low_cycles", cnt, 0);
        write(0);
        cyc();
        run_to(0);
        cyc();
        check("zero_active", duty_active, 0);
        run_to(0);
        cnt = 0;
        repeat (P) begin cyc(); if (pwm_h) cnt++; end
        check("zero_duty_h_high_cycles", cnt, 0);

        // Dead-time abort around the compare point
        write(1003);
        cyc();
        run_to(0);
        cyc();
        hold(1500, 20);
        hs = 0; lows = 0;
        for (int i = 0; i < 4; i++) begin
            hold((i % 2 == 0) ? 1002 : 1003 + i / 2, 1);
            if (pwm_h) hs++;
            if (!pwm_l) lows++;
        end
        for (int i = 0; i < 12; i++) begin
            hold(1500, 1);
            if (pwm_h) hs++;
            if (!pwm_l) lows++;
        end
        check("abort_h_cycles", hs, 0);
        check("abort_l_low_cycles", lows, 2);

        // Down count: transfer on the boundary cycle, stalled second write
        cnt_dir = 1'b1;
        cnt_in = 32'd10;
        run_to(P - 1);
        write(700);
        cyc();
        check("bypass_active", duty_active, 700);
        check("bypass_ready", duty_ready, 1);
        write(1800);
        cyc();
        check("shadow_full_ready", duty_ready, 0);
        write(900);
        repeat (3) cyc();
        check("stall_ready", duty_ready, 0);
        check("stall_active", duty_active, 700);
        run_to(P - 1);
        cyc();
        check("down_wrap_active", duty_active, 1800);
        check("down_wrap_ready", duty_ready, 1);
        cyc();
        check("held_write_taken", duty_ready, 0);
        run_to(P - 1);
        cyc();
        check("held_write_active", duty_active, 900);

        // Asynchronous reset in the middle of DT_H
        run_to(899);
        repeat (3) cyc();
        check("in_dt_h_pwm_h", pwm_h, 0);
        check("in_dt_h_pwm_l", pwm_l, 0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("async_rst_pwm_l", pwm_l, 1);
        check("async_rst_pwm_h", pwm_h, 0);
        check("async_rst_active", duty_active, 0);
        repeat (2) cyc();
        rst = 1'b1;

        // Synchronous clear in the middle of DT_H
        write(2500);
        cyc();
        run_to(P - 1);
        cyc();
        check("clr_setup_active", duty_active, 2500);
        repeat (2) cyc();
        clr = 1'b0;
        cyc();
        clr = 1'b1;
        check("clr_pwm_l", pwm_l, 1);
        check("clr_pwm_h", pwm_h, 0);
        check("clr_active", duty_active, 0);
        check("clr_ready", duty_ready, 1);
        repeat (4) cyc();

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
